multicycle_cu: RTL and testbench

Parametrised multi-cycle control unit that sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK. It drives the datapath selects, ALU function, register-file and memory strobes from a latched opcode. It sits between the instruction register and the datapath, with req/ack handshakes to instruction and data memory. It adds a data-memory timeout, illegal-opcode trapping, a HALT state and a retired-instruction counter.

---
 rtl/multicycle_cu.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_cu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_cu                                                              |
// | FETCH/DECODE/EXECUTE/MEM/WB sequencer with timeout, illegal-op trap, HALT. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multicycle_cu #(
  parameter int OPW         = 6,
  parameter int ALUW        = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNTW        = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  i_opcode,
  input  logic            i_equ,
  input  logic            i_les,
  input  logic            i_im_ack,
  input  logic            i_dm_ack,
  output logic            o_im_req,
  output logic            o_ir_load,
  output logic            o_pc_write,
  output logic [2:0]      o_pc_sel,
  output logic            o_alu_in2_sel,
  output logic [ALUW-1:0] o_alu_control,
  output logic [2:0]      o_im_control,
  output logic            o_reg_write,
  output logic [1:0]      o_wb_sel,
  output logic            o_dm_req,
  output logic            o_dm_we,
  output logic            o_dm_wdata_sel,
  output logic            o_halted,
  output logic            o_err_illegal,
  output logic            o_err_timeout,
  output logic [CNTW-1:0] o_retired,
  output logic [2:0]      o_state_dbg
);

  localparam int c_TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  state_t          r_state;
  logic [OPW-1:0]  r_op_q;
  logic [CNTW-1:0] r_retired;
  logic [c_TW-1:0] r_tcnt;
  logic            r_err_ill;
  logic            r_err_to;

  logic            w_rtype, w_mem, w_ctl, w_store, w_imm_op2;
  logic [c_TW-1:0] w_tcnt_nxt;
  logic [ALUW-1:0] w_alu;
  logic [1:0]      w_imc_hi;
  logic [1:0]      w_wb;

  assign w_rtype    = (r_op_q >= OPW'(1))  && (r_op_q <= OPW'(15));
  assign w_mem      = (r_op_q >= OPW'(24)) && (r_op_q <= OPW'(27));
  assign w_ctl      = (r_op_q >= OPW'(28)) && (r_op_q <= OPW'(31));
  assign w_imm_op2  = (r_op_q >= OPW'(18)) && (r_op_q <= OPW'(27));
  assign w_store    = (r_op_q == OPW'(25)) || (r_op_q == OPW'(27));
  assign w_tcnt_nxt = r_tcnt + c_TW'(1);
  assign w_imc_hi   = w_rtype ? 2'd2 : (w_mem ? 2'd1 : 2'd0);

  always_comb begin
    w_alu = '0;
    if (w_rtype) begin
      w_alu = ALUW'(r_op_q[3:0]);
    end else begin
      case (r_op_q)
        OPW'(16), OPW'(17), OPW'(18): w_alu = ALUW'(1);
        OPW'(19):                     w_alu = ALUW'(2);
        OPW'(20):                     w_alu = ALUW'(3);
        OPW'(21):                     w_alu = ALUW'(4);
        OPW'(22):                     w_alu = ALUW'(9);
        OPW'(23):                     w_alu = ALUW'(10);
        default:                      w_alu = '0;
      endcase
    end
  end

  always_comb begin
    case (r_op_q)
      OPW'(26): w_wb = 2'd0;
      OPW'(17): w_wb = 2'd1;
      OPW'(24): w_wb = 2'd3;
      default:  w_wb = 2'd2;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op_q    <= '0;
      r_retired <= '0;
      r_tcnt    <= '0;
      r_err_ill <= 1'b0;
      r_err_to  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= S_FETCH;
        S_FETCH: if (i_im_ack) r_state <= S_DECODE;
        S_DECODE: begin
          r_op_q <= i_opcode;
          if (i_opcode == '0) begin
            r_state <= S_HALT;
          end else if (i_opcode >= OPW'(32)) begin
            r_state   <= S_HALT;
            r_err_ill <= 1'b1;
          end else begin
            r_state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (w_ctl) begin
            r_state   <= S_FETCH;
            r_retired <= r_retired + CNTW'(1);
          end else if (w_mem) begin
            r_state <= S_MEM;
            r_tcnt  <= '0;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          // An ack in the cycle that would hit the limit still completes.
          if (i_dm_ack) begin
            if (w_store) begin
              r_state   <= S_FETCH;
              r_retired <= r_retired + CNTW'(1);
            end else begin
              r_state <= S_WB;
            end
          end else if (w_tcnt_nxt == c_TW'(MEM_TIMEOUT)) begin
            r_state  <= S_HALT;
            r_err_to <= 1'b1;
          end else begin
            r_tcnt <= w_tcnt_nxt;
          end
        end
        S_WB: begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + CNTW'(1);
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_im_req       = 1'b0;
    o_ir_load      = 1'b0;
    o_pc_write     = 1'b0;
    o_pc_sel       = 3'd4;
    o_alu_in2_sel  = 1'b0;
    o_alu_control  = '0;
    o_im_control   = 3'd0;
    o_reg_write    = 1'b0;
    o_wb_sel       = 2'd0;
    o_dm_req       = 1'b0;
    o_dm_we        = 1'b0;
    o_dm_wdata_sel = 1'b0;
    if (r_state == S_EXECUTE || r_state == S_MEM || r_state == S_WB) begin
      o_alu_control = w_alu;
      o_alu_in2_sel = ~w_imm_op2;
      o_im_control  = {w_imc_hi, ~w_ctl};
    end
    case (r_state)
      S_FETCH: begin
        o_im_req  = 1'b1;
        o_ir_load = i_im_ack;
      end
      S_EXECUTE: begin
        if (w_ctl) begin
          o_pc_write = 1'b1;
          case (r_op_q)
            OPW'(28): o_pc_sel = 3'd0;
            OPW'(29): o_pc_sel = 3'd2;
            OPW'(30): o_pc_sel = i_equ ? 3'd1 : 3'd3;
            default:  o_pc_sel = i_les ? 3'd1 : 3'd3;
          endcase
        end
      end
      S_MEM: begin
        o_dm_req       = 1'b1;
        o_dm_we        = w_store;
        o_dm_wdata_sel = (r_op_q != OPW'(27));
        if (i_dm_ack && w_store) begin
          o_pc_write = 1'b1;
          o_pc_sel   = 3'd3;
        end
      end
      S_WB: begin
        o_reg_write = 1'b1;
        o_pc_write  = 1'b1;
        o_pc_sel    = 3'd3;
        o_wb_sel    = w_wb;
      end
      default: ;
    endcase
  end

  assign o_halted      = (r_state == S_HALT);
  assign o_err_illegal = r_err_ill;
  assign o_err_timeout = r_err_to;
  assign o_retired     = r_retired;
  assign o_state_dbg   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_cu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_cu                                                           |
// | Directed vector table plus hand sequences for the control unit.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multicycle_cu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] i_opcode = '0;
  logic       i_equ = 1'b0, i_les = 1'b0, i_im_ack = 1'b0, i_dm_ack = 1'b0;
  logic       o_im_req, o_ir_load, o_pc_write, o_alu_in2_sel, o_reg_write;
  logic       o_dm_req, o_dm_we, o_dm_wdata_sel, o_halted, o_err_illegal, o_err_timeout;
  logic [2:0] o_pc_sel, o_im_control, o_state_dbg;
  logic [3:0] o_alu_control, o_retired;
  logic [1:0] o_wb_sel;

  multicycle_cu #(.OPW(6), .ALUW(4), .MEM_TIMEOUT(15), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .i_opcode(i_opcode), .i_equ(i_equ), .i_les(i_les),
    .i_im_ack(i_im_ack), .i_dm_ack(i_dm_ack), .o_im_req(o_im_req),
    .o_ir_load(o_ir_load), .o_pc_write(o_pc_write), .o_pc_sel(o_pc_sel),
    .o_alu_in2_sel(o_alu_in2_sel), .o_alu_control(o_alu_control),
    .o_im_control(o_im_control), .o_reg_write(o_reg_write), .o_wb_sel(o_wb_sel),
    .o_dm_req(o_dm_req), .o_dm_we(o_dm_we), .o_dm_wdata_sel(o_dm_wdata_sel),
    .o_halted(o_halted), .o_err_illegal(o_err_illegal),
    .o_err_timeout(o_err_timeout), .o_retired(o_retired), .o_state_dbg(o_state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic       equ;
    logic       les;
    int         dmw;
    int         cyc;
    logic [3:0] alu;
    logic       in2;
    logic [2:0] imc;
    logic [2:0] pcsel;
    logic       rw;
    logic [1:0] wb;
    int         reqn;
    logic       we;
    logic       wsel;
  } vec_t;

  vec_t       vq[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] exp_ret;

  int         t_cyc, t_reqn, t_pcwn;
  logic [2:0] tr[$];
  logic [3:0] cap_alu, cap_wb_alu;
  logic       cap_in2, cap_wb_in2, cap_rw, cap_we, cap_wsel, cap_irl;
  logic [2:0] cap_imc, cap_pcsel;
  logic [1:0] cap_wb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs one instruction from a FETCH negedge until FETCH or HALT is seen again.
  task automatic run_instr(input logic [5:0] op, input logic e, input logic l, input int dmw);
    int memn;
    memn = 0; t_cyc = 0; t_reqn = 0; t_pcwn = 0; tr.delete();
    cap_alu = '0; cap_in2 = 0; cap_imc = '0; cap_rw = 0; cap_wb = '0;
    cap_we = 0; cap_wsel = 0; cap_irl = 0; cap_wb_alu = '0; cap_wb_in2 = 0;
    i_opcode = op; i_equ = e; i_les = l; i_im_ack = 1'b1; i_dm_ack = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tr.push_back(o_state_dbg);
      if (o_state_dbg == 3'd4) begin
        i_dm_ack = (memn >= dmw);
        memn++;
      end else begin
        i_dm_ack = 1'b0;
      end
      #1;
      if (o_state_dbg == 3'd1) cap_irl = o_ir_load;
      if (o_state_dbg == 3'd3) begin
        cap_alu = o_alu_control; cap_in2 = o_alu_in2_sel; cap_imc = o_im_control;
      end
      if (o_state_dbg == 3'd4) begin
        cap_we = o_dm_we; cap_wsel = o_dm_wdata_sel;
      end
      if (o_state_dbg == 3'd5) begin
        cap_rw = o_reg_write; cap_wb = o_wb_sel;
        cap_wb_alu = o_alu_control; cap_wb_in2 = o_alu_in2_sel;
      end
      if (o_dm_req) t_reqn++;
      if (o_pc_write) t_pcwn++;
      cap_pcsel = o_pc_sel;
      @(negedge clk);
      t_cyc++;
      if (o_state_dbg == 3'd1 || o_state_dbg == 3'd6) break;
    end
    i_dm_ack = 1'b0;
  endtask

  task automatic do_reset();
    i_im_ack = 1'b0; i_dm_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_ret = '0;
  endtask

  initial begin
    vq.push_back('{6'd18, 0, 0, 0,  4, 4'd1,  0, 3'b001, 3'd3, 1, 2'd2, 0,  0, 0});
    vq.push_back('{6'd5,  0, 0, 0,  4, 4'd5,  1, 3'b101, 3'd3, 1, 2'd2, 0,  0, 0});
    vq.push_back('{6'd15, 0, 0, 0,  4, 4'd15, 1, 3'b101, 3'd3, 1, 2'd2, 0,  0, 0});
    vq.push_back('{6'd16, 0, 0, 0,  4, 4'd1,  1, 3'b001, 3'd3, 1, 2'd2, 0,  0, 0});
    vq.push_back('{6'd17, 0, 0, 0,  4, 4'd1,  1, 3'b001, 3'd3, 1, 2'd1, 0,  0, 0});
    vq.push_back('{6'd19, 0, 0, 0,  4, 4'd2,  0, 3'b001, 3'd3, 1, 2'd2, 0,  0, 0});
    vq.push_back('{6'd20, 0, 0, 0,  4, 4'd3,  0, 3'b001, 3'd3, 1, 2'd2, 0,  0, 0});
    vq.push_back('{6'd21, 0, 0, 0,  4, 4'd4,  0, 3'b001, 3'd3, 1, 2'd2, 0,  0, 0});
    vq.push_back('{6'd22, 0, 0, 0,  4, 4'd9,  0, 3'b001, 3'd3, 1, 2'd2, 0,  0, 0});
    vq.push_back('{6'd23, 0, 0, 0,  4, 4'd10, 0, 3'b001, 3'd3, 1, 2'd2, 0,  0, 0});
    vq.push_back('{6'd30, 1, 0, 0,  3, 4'd0,  1, 3'b000, 3'd1, 0, 2'd0, 0,  0, 0});
    vq.push_back('{6'd30, 0, 1, 0,  3, 4'd0,  1, 3'b000, 3'd3, 0, 2'd0, 0,  0, 0});
    vq.push_back('{6'd31, 0, 1, 0,  3, 4'd0,  1, 3'b000, 3'd1, 0, 2'd0, 0,  0, 0});
    vq.push_back('{6'd31, 1, 0, 0,  3, 4'd0,  1, 3'b000, 3'd3, 0, 2'd0, 0,  0, 0});
    vq.push_back('{6'd28, 0, 0, 0,  3, 4'd0,  1, 3'b000, 3'd0, 0, 2'd0, 0,  0, 0});
    vq.push_back('{6'd29, 0, 0, 0,  3, 4'd0,  1, 3'b000, 3'd2, 0, 2'd0, 0,  0, 0});
    vq.push_back('{6'd24, 0, 0, 0,  5, 4'd0,  0, 3'b011, 3'd3, 1, 2'd3, 1,  0, 1});
    vq.push_back('{6'd26, 0, 0, 2,  7, 4'd0,  0, 3'b011, 3'd3, 1, 2'd0, 3,  0, 1});
    vq.push_back('{6'd25, 0, 0, 0,  4, 4'd0,  0, 3'b011, 3'd3, 0, 2'd0, 1,  1, 1});
    vq.push_back('{6'd27, 0, 0, 3,  7, 4'd0,  0, 3'b011, 3'd3, 0, 2'd0, 4,  1, 0});
    vq.push_back('{6'd24, 0, 0, 14, 19, 4'd0, 0, 3'b011, 3'd3, 1, 2'd3, 15, 0, 1});

    exp_ret = '0;
    repeat (2) @(negedge clk);
    chk("rst state", 32'(o_state_dbg), 0);
    chk("rst pc_sel", 32'(o_pc_sel), 4);
    chk("rst strobes", 32'({o_im_req, o_pc_write, o_reg_write, o_dm_req, o_halted,
                            o_err_illegal, o_err_timeout}), 0);
    chk("rst retired", 32'(o_retired), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle->fetch", 32'(o_state_dbg), 1);
    chk("fetch im_req", 32'(o_im_req), 1);

    run_instr(6'd18, 1'b0, 1'b0, 0);
    chk("addi trace len", 32'(tr.size()), 4);
    if (tr.size() == 4) chk("addi trace", 32'({tr[0], tr[1], tr[2], tr[3]}), 32'(12'o1235));
    chk("addi back in fetch", 32'(o_state_dbg), 1);
    chk("addi ir_load", 32'(cap_irl), 1);
    chk("addi wb reg_write", 32'(cap_rw), 1);
    chk("addi wb alu", 32'(cap_wb_alu), 1);
    chk("addi wb in2", 32'(cap_wb_in2), 0);
    chk("addi wb_sel", 32'(cap_wb), 2);
    exp_ret = exp_ret + 4'd1;
    chk("addi retired", 32'(o_retired), 32'(exp_ret));

    foreach (vq[i]) begin
      run_instr(vq[i].op, vq[i].equ, vq[i].les, vq[i].dmw);
      exp_ret = exp_ret + 4'd1;
      chk($sformatf("v%0d op%0d cycles", i, vq[i].op), 32'(t_cyc), 32'(vq[i].cyc));
      chk($sformatf("v%0d op%0d alu", i, vq[i].op), 32'(cap_alu), 32'(vq[i].alu));
      chk($sformatf("v%0d op%0d in2", i, vq[i].op), 32'(cap_in2), 32'(vq[i].in2));
      chk($sformatf("v%0d op%0d im_ctl", i, vq[i].op), 32'(cap_imc), 32'(vq[i].imc));
      chk($sformatf("v%0d op%0d pcw cnt", i, vq[i].op), 32'(t_pcwn), 1);
      chk($sformatf("v%0d op%0d pc_sel", i, vq[i].op), 32'(cap_pcsel), 32'(vq[i].pcsel));
      chk($sformatf("v%0d op%0d reg_wr", i, vq[i].op), 32'(cap_rw), 32'(vq[i].rw));
      chk($sformatf("v%0d op%0d wb_sel", i, vq[i].op), 32'(cap_wb), 32'(vq[i].wb));
      chk($sformatf("v%0d op%0d dm_req n", i, vq[i].op), 32'(t_reqn), 32'(vq[i].reqn));
      chk($sformatf("v%0d op%0d dm_we", i, vq[i].op), 32'(cap_we), 32'(vq[i].we));
      chk($sformatf("v%0d op%0d wdsel", i, vq[i].op), 32'(cap_wsel), 32'(vq[i].wsel));
      chk($sformatf("v%0d op%0d retired", i, vq[i].op), 32'(o_retired), 32'(exp_ret));
    end

    run_instr(6'd24, 1'b0, 1'b0, 1000);
    chk("tmo state", 32'(o_state_dbg), 6);
    chk("tmo mem cycles", 32'(t_reqn), 15);
    chk("tmo flags", 32'({o_err_timeout, o_halted, o_err_illegal}), 32'(3'b110));
    chk("tmo retired", 32'(o_retired), 32'(exp_ret));
    chk("halt strobes", 32'({o_pc_write, o_dm_req, o_reg_write, o_im_req}), 0);
    chk("halt pc_sel", 32'(o_pc_sel), 4);

    do_reset();
    run_instr(6'd40, 1'b0, 1'b0, 0);
    chk("ill state", 32'(o_state_dbg), 6);
    chk("ill flags", 32'({o_err_illegal, o_halted, o_err_timeout}), 32'(3'b110));
    chk("ill retired", 32'(o_retired), 0);

    do_reset();
    run_instr(6'd0, 1'b0, 1'b0, 0);
    chk("op0 state", 32'(o_state_dbg), 6);
    chk("op0 flags", 32'({o_err_illegal, o_halted}), 32'(2'b01));

    do_reset();
    for (int n = 0; n < 17; n++) run_instr(6'd18, 1'b0, 1'b0, 0);
    chk("wrap retired", 32'(o_retired), 1);

    i_opcode = 6'd24; i_im_ack = 1'b1; i_dm_ack = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_state_dbg == 3'd4) break;
    end
    chk("reach mem", 32'(o_state_dbg), 4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst state", 32'(o_state_dbg), 0);
    chk("midrst strobes", 32'({o_dm_req, o_pc_write, o_reg_write, o_alu_control,
                               o_im_control, o_alu_in2_sel}), 0);
    chk("midrst pc_sel", 32'(o_pc_sel), 4);
    chk("midrst retired", 32'(o_retired), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
